// File: rtl/regfile_port_ctrl.sv
// Owner of the register file write port: post-reset zeroing sweep, core/debug write
// arbitration with a starvation breaker, and a registered debug read path.
module regfile_port_ctrl #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          CORE_WE,
    input  logic [AW-1:0] CORE_A3,
    input  logic [DW-1:0] CORE_WD,
    output logic          CORE_STALL,
    input  logic          DBG_VALID,
    input  logic          DBG_WRITE,
    input  logic [AW-1:0] DBG_ADDR,
    input  logic [DW-1:0] DBG_WDATA,
    output logic          DBG_READY,
    output logic          DBG_RVALID,
    output logic [DW-1:0] DBG_RDATA,
    output logic [AW-1:0] RF_A3,
    output logic [DW-1:0] RF_WD3,
    output logic          RF_WE3,
    output logic [AW-1:0] RF_RA,
    input  logic [DW-1:0] RF_RD,
    output logic          INIT_DONE
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [AW-1:0] LastAddr  = '1;
    localparam logic [3:0]    StarveMax = 4'(STARVE_LIM - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [3:0]    starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          done_q, done_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic core_own, dbg_wr_req, dbg_rd_req;

    assign core_own   = !stall_q && CORE_WE;
    assign dbg_wr_req = DBG_VALID && DBG_WRITE;
    assign dbg_rd_req = DBG_VALID && !DBG_WRITE;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        starve_d   = starve_q;
        stall_d    = stall_q;
        done_d     = done_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        RF_WE3     = 1'b0;
        RF_A3      = '0;
        RF_WD3     = '0;
        DBG_READY  = 1'b0;

        unique case (state_q)
            StInit: begin
                // Gate with reset so the port is quiet while reset is held.
                RF_WE3     = RESETN;
                RF_A3      = init_cnt_q;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastAddr) begin
                    state_d = StRun;
                    stall_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                stall_d = 1'b0;
                if (core_own) begin
                    RF_A3  = CORE_A3;
                    RF_WD3 = CORE_WD;
                    RF_WE3 = (CORE_A3 != '0);
                end else if (dbg_wr_req) begin
                    RF_A3     = DBG_ADDR;
                    RF_WD3    = DBG_WDATA;
                    RF_WE3    = (DBG_ADDR != '0);
                    DBG_READY = 1'b1;
                end

                if (dbg_rd_req) begin
                    DBG_READY = 1'b1;
                    rvalid_d  = 1'b1;
                    rdata_d   = (DBG_ADDR == '0) ? '0 : RF_RD;
                end

                // A blocked write that hits the limit buys one stalled cycle for debug.
                if (!DBG_VALID || (DBG_WRITE && DBG_READY)) begin
                    starve_d = '0;
                end else if (DBG_WRITE) begin
                    if (starve_q >= StarveMax) begin
                        starve_d = '0;
                        stall_d  = 1'b1;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= StInit;
            init_cnt_q <= AW'(1);
            starve_q   <= '0;
            stall_q    <= 1'b1;
            done_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign CORE_STALL = stall_q;
    assign INIT_DONE  = done_q;
    assign DBG_RVALID = rvalid_q;
    assign DBG_RDATA  = rdata_q;
    assign RF_RA      = DBG_ADDR;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: a behavioural model predicts writes, read data
// and status; a negedge monitor pops and compares what the DUT presents.
module tb_regfile_port_ctrl;

    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        CORE_WE;
    logic [4:0]  CORE_A3;
    logic [31:0] CORE_WD;
    logic        CORE_STALL;
    logic        DBG_VALID;
    logic        DBG_WRITE;
    logic [4:0]  DBG_ADDR;
    logic [31:0] DBG_WDATA;
    logic        DBG_READY;
    logic        DBG_RVALID;
    logic [31:0] DBG_RDATA;
    logic [4:0]  RF_A3;
    logic [31:0] RF_WD3;
    logic        RF_WE3;
    logic [4:0]  RF_RA;
    logic [31:0] RF_RD;
    logic        INIT_DONE;

    regfile_port_ctrl #(.AW(5), .DW(32), .STARVE_LIM(LIM)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .CORE_WE    (CORE_WE),
        .CORE_A3    (CORE_A3),
        .CORE_WD    (CORE_WD),
        .CORE_STALL (CORE_STALL),
        .DBG_VALID  (DBG_VALID),
        .DBG_WRITE  (DBG_WRITE),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_WDATA  (DBG_WDATA),
        .DBG_READY  (DBG_READY),
        .DBG_RVALID (DBG_RVALID),
        .DBG_RDATA  (DBG_RDATA),
        .RF_A3      (RF_A3),
        .RF_WD3     (RF_WD3),
        .RF_WE3     (RF_WE3),
        .RF_RA      (RF_RA),
        .RF_RD      (RF_RD),
        .INIT_DONE  (INIT_DONE)
    );

    always #5 CLK = ~CLK;

    // Register file stand-in; x0 holds a non-zero value to prove read masking.
    logic [31:0] rf [32];
    logic        preload;
    assign RF_RD = rf[RF_RA];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0000FFFF : (32'hDEAD0000 | 32'(i));
        end else if (RF_WE3) begin
            rf[RF_A3] <= RF_WD3;
        end
    end

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic stall; logic done; logic ready; } st_t;

    wr_t         wq[$];
    st_t         sq[$];
    logic [31:0] rq[$];
    logic [31:0] rdue[$];

    bit          m_done, m_stall;
    int          m_next, m_starve;
    logic [31:0] shadow [32];

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    bit rel_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_done = 0; m_stall = 1; m_next = 1; m_starve = 0;
        wq.delete(); sq.delete(); rq.delete(); rdue.delete();
    endtask

    task automatic model_step(input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                              input logic dv, input logic dw, input logic [4:0] da,
                              input logic [31:0] dd, output logic acc);
        st_t s;
        wr_t w;
        logic core_owns;
        s.stall = m_stall; s.done = m_done;
        acc = 1'b0;
        if (!m_done) begin
            w.a = m_next[4:0]; w.d = 32'h0;
            wq.push_back(w);
            shadow[m_next] = 32'h0;
            if (m_next == 31) begin m_done = 1; m_stall = 0; end
            m_next++;
        end else begin
            core_owns = !m_stall && cwe;
            acc = dv && (!dw || !core_owns);
            // Reads see the register contents before this cycle's write.
            if (dv && !dw) rq.push_back((da == 0) ? 32'h0 : shadow[da]);
            if (core_owns) begin
                if (ca != 0) begin w.a = ca; w.d = cwd; wq.push_back(w); shadow[ca] = cwd; end
            end else if (dv && dw && da != 0) begin
                w.a = da; w.d = dd; wq.push_back(w); shadow[da] = dd;
            end
            m_stall = 0;
            if (dv && dw && !acc) begin
                m_starve++;
                if (m_starve == LIM) begin m_stall = 1; m_starve = 0; end
            end else if (!dv || (dw && acc)) begin
                m_starve = 0;
            end
        end
        s.ready = acc;
        sq.push_back(s);
    endtask

    task automatic cycle(input logic cwe, input logic [4:0] ca, input logic [31:0] cwd,
                         input logic dv, input logic dw, input logic [4:0] da,
                         input logic [31:0] dd, output logic acc);
        @(posedge CLK);
        #1;
        if (rel_pend) begin RESETN = 1'b1; rel_pend = 0; end
        CORE_WE = cwe; CORE_A3 = ca; CORE_WD = cwd;
        DBG_VALID = dv; DBG_WRITE = dw; DBG_ADDR = da; DBG_WDATA = dd;
        model_step(cwe, ca, cwd, dv, dw, da, dd, acc);
        mon_en = 1;
    endtask

    st_t         mon_s;
    wr_t         mon_w;
    logic [31:0] mon_r;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (sq.size() == 0) begin
                check("status_queue_empty", 32'(sq.size()), 1);
            end else begin
                mon_s = sq.pop_front();
                check("CORE_STALL", {31'b0, CORE_STALL}, {31'b0, mon_s.stall});
                check("INIT_DONE", {31'b0, INIT_DONE}, {31'b0, mon_s.done});
                check("DBG_READY", {31'b0, DBG_READY}, {31'b0, mon_s.ready});
            end
            if (RF_WE3) begin
                if (wq.size() == 0) begin
                    check("RF_WE3_unexpected", {31'b0, RF_WE3}, 0);
                end else begin
                    mon_w = wq.pop_front();
                    check("RF_A3", {27'b0, RF_A3}, {27'b0, mon_w.a});
                    check("RF_WD3", RF_WD3, mon_w.d);
                end
            end else if (wq.size() != 0) begin
                mon_w = wq.pop_front();
                check("RF_WE3_missing", {31'b0, RF_WE3}, 1);
            end
            if (DBG_RVALID) begin
                if (rdue.size() == 0) begin
                    check("DBG_RVALID_unexpected", {31'b0, DBG_RVALID}, 0);
                end else begin
                    mon_r = rdue.pop_front();
                    check("DBG_RDATA", DBG_RDATA, mon_r);
                end
            end else if (rdue.size() != 0) begin
                mon_r = rdue.pop_front();
                check("DBG_RVALID_missing", {31'b0, DBG_RVALID}, 1);
            end
            while (rq.size() != 0) rdue.push_back(rq.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_CORE_STALL"}, {31'b0, CORE_STALL}, 1);
        check({tag, "_INIT_DONE"}, {31'b0, INIT_DONE}, 0);
        check({tag, "_DBG_RVALID"}, {31'b0, DBG_RVALID}, 0);
        check({tag, "_DBG_RDATA"}, DBG_RDATA, 0);
        check({tag, "_RF_WE3"}, {31'b0, RF_WE3}, 0);
        check({tag, "_DBG_READY"}, {31'b0, DBG_READY}, 0);
    endtask

    logic        acc, pend, rv, rw, dv;
    logic [4:0]  ra;
    logic [31:0] rdd;
    int          pulses, gidx;

    initial begin
        RESETN = 1'b0; preload = 1'b1;
        CORE_WE = 0; CORE_A3 = 0; CORE_WD = 0;
        DBG_VALID = 1; DBG_WRITE = 0; DBG_ADDR = 3; DBG_WDATA = 0;
        @(posedge CLK);
        #1;
        preload = 1'b0;
        check_reset_outputs("por");
        model_reset();
        rel_pend = 1;

        // Sweep with a pending debug write and random core traffic, all ignored.
        for (int i = 0; i < 31; i++)
            cycle(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b1, 1'b1, 5'd3, 32'hBAD, acc);

        // Core wins over a simultaneous debug write, which goes next cycle.
        cycle(1'b1, 5'd7, 32'h1234, 1'b1, 1'b1, 5'd9, 32'h99, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h99, acc);

        // Starvation: core hogs the port, debug write to x5 must break through.
        pend = 1; pulses = 0; gidx = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'(10 + i), 32'h5000 + 32'(i), pend, 1'b1, 5'd5, 32'hA5, acc);
            #1;
            if (CORE_STALL) pulses++;
            if (pend && DBG_READY && gidx < 0) gidx = i;
            if (acc) pend = 0;
        end
        check("starve_stall_pulses", 32'(pulses), 1);
        check("starve_grant_cycle", 32'(gidx), 4);

        // Reads, including x0 masking.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd6, 32'h110, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd6, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, acc);
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 5'd5, 32'h0, acc);

        // Address-0 writes from both sides must not reach the file.
        cycle(1'b1, 5'd0, 32'hFACE, 1'b0, 1'b0, 5'd0, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hBEEF, acc);

        // Same-cycle core write and read: old value returned, new one visible after.
        cycle(1'b1, 5'd6, 32'h777, 1'b1, 1'b0, 5'd6, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd6, 32'h0, acc);

        // Randomized traffic obeying the hold-until-accept rule.
        rv = 0; rw = 0; ra = 0; rdd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!rv && $urandom_range(0, 2) == 0) begin
                rv = 1; rw = 1'($urandom_range(0, 1)); ra = 5'($urandom_range(0, 31)); rdd = $urandom;
            end
            dv = rv;
            if (rv && $urandom_range(0, 15) == 0) begin dv = 0; rv = 0; end
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  dv, rw, ra, rdd, acc);
            if (acc) rv = 0;
        end

        // Reset in RUN with non-zero read data held.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd5, 32'hA5, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, acc);
        @(posedge CLK);
        #1;
        mon_en = 0;
        DBG_VALID = 1; DBG_WRITE = 0;
        RESETN = 1'b0;
        #1;
        check_reset_outputs("run_rst");
        model_reset();
        rel_pend = 1;

        // Partial sweep, then reset while address 15 is being written.
        for (int i = 0; i < 14; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'b0, 1'b0, 5'd0, 32'h0, acc);
        @(posedge CLK);
        #1;
        mon_en = 0;
        check("sweep_addr_before_rst", {27'b0, RF_A3}, 15);
        RESETN = 1'b0;
        #1;
        check_reset_outputs("sweep_rst");
        model_reset();
        rel_pend = 1;

        for (int i = 0; i < 31; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'b0, 1'b0, 5'd0, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0, acc);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0, acc);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, acc);
        @(posedge CLK);
        #1;
        mon_en = 0;
        check("scoreboard_drained", 32'(wq.size() + sq.size() + rq.size() + rdue.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
